// File: rtl/uart_program_loader_if.sv
// uart_program_loader_if: groups the byte-stream input from uart_rx and the RAM
// write port / status outputs of the boot-time program loader.
//   slave  modport : the loader (consumes rx_*, drives mem_* and status)
//   master modport : the host side (drives rx_*, observes mem_* and status)
// Signals:
//   rx_data[7:0]        received byte, valid only while rx_ready is high
//   rx_ready            one-cycle strobe: a byte is available
//   ferr                framing error, qualified by rx_ready
//   mem_we              one-cycle RAM write strobe
//   mem_addr[ADDR_W-1:0] RAM word address
//   mem_wdata[31:0]     RAM write data
//   cpu_run             load completed, releases the core
//   load_err            sticky error flag
//   busy                load in progress
interface uart_program_loader_if #(
  parameter int unsigned ADDR_W = 15
) ();
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              ferr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_run;
  logic              load_err;
  logic              busy;

  modport slave (
    input  rx_data,
    input  rx_ready,
    input  ferr,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output cpu_run,
    output load_err,
    output busy
  );

  modport master (
    output rx_data,
    output rx_ready,
    output ferr,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  cpu_run,
    input  load_err,
    input  busy
  );
endinterface

// File: rtl/uart_program_loader.sv
// uart_program_loader: boot-time loader. Takes a byte stream (4-byte big-endian
// word count N, then N big-endian 32-bit words), writes the words to RAM from
// word address 0 upward, then raises cpu_run. Framing errors and oversize
// programs latch load_err and the core is never released.
// Optional feature macro: LOADER_CHECKSUM_EN -- when defined, a trailing byte
// holding the XOR of all payload bytes must match before cpu_run rises.
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous active-high reset
//   bus_io  uart_program_loader_if.slave (rx byte input, RAM write port, status)
module uart_program_loader #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned MAX_WORDS = 32768
) (
  input logic                  clk_i,
  input logic                  rst_i,
  uart_program_loader_if.slave bus_io
);

  // One extra bit so N = 2^ADDR_W completes without wrapping.
  localparam int unsigned CntW = ADDR_W + 1;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    StHdr  = 3'd0,
    StLoad = 3'd1,
    StDone = 3'd2,
    StErr  = 3'd3,
    StChk  = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    StHdr  = 3'd0,
    StLoad = 3'd1,
    StDone = 3'd2,
    StErr  = 3'd3
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [CntW-1:0]   word_cnt_q, word_cnt_d;
  logic [31:0]       n_q, n_d;
  logic [31:0]       asm_q, asm_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              busy, cpu_run, load_err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StHdr;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      n_q         <= '0;
      asm_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      n_q         <= n_d;
      asm_q       <= asm_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    n_d         = n_q;
    asm_d       = asm_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d       = chk_q;
`endif

    unique case (state_q)
      StHdr: begin
        if (bus_io.rx_ready) begin
          if (bus_io.ferr) begin
            state_d = StErr;
          end else begin
            n_d        = {n_q[23:0], bus_io.rx_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              if (n_d == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                state_d = StChk;
`else
                state_d = StDone;
`endif
              end else if (n_d > MAX_WORDS) begin
                state_d = StErr;
              end else begin
                state_d = StLoad;
              end
            end
          end
        end
      end

      StLoad: begin
        if (bus_io.rx_ready) begin
          if (bus_io.ferr) begin
            // Partially assembled word is dropped; nothing is written.
            state_d = StErr;
          end else begin
            asm_d      = {asm_q[23:0], bus_io.rx_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            chk_d      = chk_q ^ bus_io.rx_data;
`endif
            if (byte_cnt_q == 2'd3) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = word_cnt_q[ADDR_W-1:0];
              mem_wdata_d = asm_d;
              word_cnt_d  = word_cnt_q + 1'b1;
              if (32'(word_cnt_d) == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                state_d = StChk;
`else
                state_d = StDone;
`endif
              end
            end
          end
        end
      end

`ifdef LOADER_CHECKSUM_EN
      StChk: begin
        if (bus_io.rx_ready) begin
          if (bus_io.ferr || (bus_io.rx_data != chk_q)) begin
            state_d = StErr;
          end else begin
            state_d = StDone;
          end
        end
      end
`endif

      // StDone and StErr are terminal until reset.
      default: ;
    endcase
  end

  // Status outputs decoded from the state register, so they change exactly
  // one cycle after the byte that caused the transition.
  always_comb begin
    busy     = 1'b0;
    cpu_run  = 1'b0;
    load_err = 1'b0;
    unique case (state_q)
      StHdr:  busy     = (byte_cnt_q != 2'd0);
      StLoad: busy     = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      StChk:  busy     = 1'b1;
`endif
      StDone: cpu_run  = 1'b1;
      StErr:  load_err = 1'b1;
      default: ;
    endcase
  end

  assign bus_io.mem_we    = mem_we_q;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_wdata = mem_wdata_q;
  assign bus_io.cpu_run   = cpu_run;
  assign bus_io.load_err  = load_err;
  assign bus_io.busy      = busy;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader. RAM writes are checked against a
// scoreboard queue filled as stimulus is driven; status outputs are checked at
// fixed points after each byte. Built with a small RAM (ADDR_W=2, MAX_WORDS=4)
// so the full-size load and the oversize header are both reachable.
module tb_uart_program_loader;

  localparam int unsigned AW = 2;
  localparam int unsigned MW = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;

  uart_program_loader_if #(.ADDR_W(AW)) bus ();

  uart_program_loader #(
    .ADDR_W   (AW),
    .MAX_WORDS(MW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int         total   = 0;
  int         bad     = 0;
  int         nwrites = 0;
  int         n0;
  wr_t        sb[$];
  logic [7:0] xacc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.mem_we === 1'b1) begin
      wr_t e;
      nwrites++;
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL wr_unexpected: observed addr=%0d data=%h expected=no write",
               bus.mem_addr, bus.mem_wdata);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
        check("wr_data", bus.mem_wdata, e.data);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One byte in one cycle; rx_data is scrambled while rx_ready is low.
  task automatic send(input logic [7:0] b, input logic fe = 1'b0);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    bus.ferr     = fe;
    @(posedge clk);
    #1;
    bus.rx_ready = 1'b0;
    bus.ferr     = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic send_hdr(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send(n[31-8*i -: 8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      xacc ^= w[31-8*i -: 8];
      send(w[31-8*i -: 8]);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"},    32'(bus.mem_we),    32'd0);
    check({tag, "_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, "_wdata"}, bus.mem_wdata,      32'd0);
    check({tag, "_run"},   32'(bus.cpu_run),   32'd0);
    check({tag, "_err"},   32'(bus.load_err),  32'd0);
    check({tag, "_busy"},  32'(bus.busy),      32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_async_run", 32'(bus.cpu_run), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(1);
    xacc = 8'h00;
  endtask

  // Header 2, words 0x12345678 / 0xDEADBEEF; checks cpu_run lands with last write.
  task automatic normal_load(input string tag);
    sb.push_back('{addr: 2'd0, data: 32'h1234_5678});
    sb.push_back('{addr: 2'd1, data: 32'hDEAD_BEEF});
    n0 = nwrites;
    send(8'h00);
    check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
    send(8'h00);
    send(8'h00);
    send(8'h02);
    send_word(32'h1234_5678);
    check({tag, "_run_early"}, 32'(bus.cpu_run), 32'd0);
    send_word(32'hDEAD_BEEF);
    check({tag, "_we_last"}, 32'(bus.mem_we), 32'd1);
`ifdef LOADER_CHECKSUM_EN
    check({tag, "_run_prechk"}, 32'(bus.cpu_run), 32'd0);
    check({tag, "_busy_prechk"}, 32'(bus.busy), 32'd1);
    send(xacc);
`endif
    check({tag, "_run"}, 32'(bus.cpu_run), 32'd1);
    check({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
    check({tag, "_err"}, 32'(bus.load_err), 32'd0);
    send(8'hA5);
    send_word(32'h0BAD_0BAD);
    idle(3);
    check({tag, "_nwr"}, 32'(nwrites - n0), 32'd2);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check({tag, "_run_hold"}, 32'(bus.cpu_run), 32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_ready = 1'b0;
    bus.ferr     = 1'b0;
    xacc         = 8'h00;
    idle(2);
    rst = 1'b0;
    idle(1);
    check_zero("reset");

    // Normal two-word load.
    normal_load("norm");

    // Zero length.
    do_reset();
    check_zero("rst_after_run");
    n0 = nwrites;
    send_hdr(32'd0);
`ifdef LOADER_CHECKSUM_EN
    check("zero_run_prechk", 32'(bus.cpu_run), 32'd0);
    send(8'h00);
`endif
    check("zero_run", 32'(bus.cpu_run), 32'd1);
    check("zero_busy", 32'(bus.busy), 32'd0);
    idle(2);
    check("zero_nwr", 32'(nwrites - n0), 32'd0);

    // Oversize header (MAX_WORDS + 1).
    do_reset();
    n0 = nwrites;
    send_hdr(32'd5);
    check("over_err", 32'(bus.load_err), 32'd1);
    check("over_busy", 32'(bus.busy), 32'd0);
    check("over_run", 32'(bus.cpu_run), 32'd0);
    send_word(32'h1122_3344);
    idle(2);
    check("over_nwr", 32'(nwrites - n0), 32'd0);
    check("over_err_hold", 32'(bus.load_err), 32'd1);

    // Largest legal program (N = MAX_WORDS = 2^ADDR_W), with idle gaps.
    do_reset();
    n0 = nwrites;
    for (int i = 0; i < 4; i++)
      sb.push_back('{addr: 2'(i), data: 32'hA0B0_C000 + 32'(i)});
    send_hdr(32'd4);
    for (int i = 0; i < 4; i++) begin
      send_word(32'hA0B0_C000 + 32'(i));
      if (i < 3) begin
        check("max_busy_gap", 32'(bus.busy), 32'd1);
        idle(2);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send(xacc);
`endif
    check("max_run", 32'(bus.cpu_run), 32'd1);
    idle(2);
    check("max_nwr", 32'(nwrites - n0), 32'd4);
    check("max_sb_empty", 32'(sb.size()), 32'd0);

    // Framing error on 3rd byte of word 1.
    do_reset();
    n0 = nwrites;
    sb.push_back('{addr: 2'd0, data: 32'hCAFE_F00D});
    send_hdr(32'd2);
    send_word(32'hCAFE_F00D);
    send(8'h11);
    send(8'h22);
    send(8'h33, 1'b1);
    check("ferr_err", 32'(bus.load_err), 32'd1);
    check("ferr_we", 32'(bus.mem_we), 32'd0);
    check("ferr_busy", 32'(bus.busy), 32'd0);
    send(8'h44);
    send_word(32'h5566_7788);
    idle(2);
    check("ferr_nwr", 32'(nwrites - n0), 32'd1);
    check("ferr_run", 32'(bus.cpu_run), 32'd0);
    check("ferr_sb_empty", 32'(sb.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum good and bad.
    do_reset();
    sb.push_back('{addr: 2'd0, data: 32'h0102_0304});
    send_hdr(32'd1);
    send_word(32'h0102_0304);
    send(8'h04);
    check("chk_good_run", 32'(bus.cpu_run), 32'd1);
    do_reset();
    n0 = nwrites;
    sb.push_back('{addr: 2'd0, data: 32'h0102_0304});
    send_hdr(32'd1);
    send_word(32'h0102_0304);
    send(8'h05);
    check("chk_bad_err", 32'(bus.load_err), 32'd1);
    check("chk_bad_run", 32'(bus.cpu_run), 32'd0);
    idle(2);
    check("chk_bad_nwr", 32'(nwrites - n0), 32'd1);
`endif

    // Reset after 6 bytes, then a full resend.
    do_reset();
    send_hdr(32'd2);
    send(8'h99);
    send(8'h88);
    check("mid_busy", 32'(bus.busy), 32'd1);
    do_reset();
    check_zero("mid_rst");
    normal_load("resend");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
